alu_mdu: RTL and testbench

Parametrised execute-stage arithmetic unit for the multi-cycle processor. It supports the full base integer ALU operation set plus the RV32M multiply/divide/remainder operations. Operands enter and results leave through valid/ready handshakes. Base operations complete in one cycle; multiply and divide run an iterative WIDTH-cycle datapath under a small FSM, so the core can stall on `busy`.

---
 rtl/alu_mdu.sv | 182 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Execute-stage integer ALU with an iterative RV32M multiply/divide unit.
// Single-cycle base ops; mul/div take WIDTH cycles in CALC behind a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// CALC  | iterating the shift-add multiplier or restoring divider, busy high
// DONE  | result valid, held until the consumer takes it
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic [4:0]       operator,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] result_nx;
    logic [SHW-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0] hi, hi_nx, lo, lo_nx, b_reg, b_nx;
    logic [2:0]       op_reg, op_nx;
    logic             neg_reg, neg_nx;
    logic             take;

    // Base ALU
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    assign shamt = operand_2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (operator)
            5'b00000: alu_res = operand_1 + operand_2;
            5'b00001: alu_res = operand_1 - operand_2;
            5'b00010: alu_res = operand_1 << shamt;
            5'b00011: alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_1) < $signed(operand_2)};
            5'b00100: alu_res = {{(WIDTH-1){1'b0}}, operand_1 < operand_2};
            5'b00101: alu_res = operand_1 ^ operand_2;
            5'b00110: alu_res = operand_1 >> shamt;
            5'b00111: alu_res = WIDTH'($signed(operand_1) >>> shamt);
            5'b01000: alu_res = operand_1 | operand_2;
            5'b01001: alu_res = operand_1 & operand_2;
            5'b01010: alu_res = operand_2;
            default:  alu_res = '0;
        endcase
    end

    // MDU decode: operator[2] selects divide, operator[1] remainder / high half
    logic             is_mdu, div_zero, div_ovf, special;
    logic [WIDTH-1:0] spec_res;
    logic             sa, sb, a_neg, b_neg, neg_acc;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mdu   = (operator[4:3] == 2'b10);
    assign div_zero = (operand_2 == '0);
    assign div_ovf  = !operator[0] && (operand_1 == MIN_VAL) && (operand_2 == ALL_ONE);
    assign special  = is_mdu && operator[2] && (div_zero || div_ovf);
    assign spec_res = div_zero ? (operator[1] ? operand_1 : ALL_ONE)
                               : (operator[1] ? '0 : operand_1);

    assign sa      = operator[2] ? !operator[0] : (operator[1] ^ operator[0]);
    assign sb      = operator[2] ? !operator[0] : (operator[1:0] == 2'b01);
    assign a_neg   = sa && operand_1[WIDTH-1];
    assign b_neg   = sb && operand_2[WIDTH-1];
    assign a_mag   = a_neg ? -operand_1 : operand_1;
    assign b_mag   = b_neg ? -operand_2 : operand_2;
    assign neg_acc = (operator[2] && operator[1]) ? a_neg : (a_neg ^ b_neg);

    // One iteration. Multiply keeps the product in {hi, lo} with the multiplier
    // shifting out of lo; divide keeps remainder in hi and dividend/quotient in lo.
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_sub, it_hi, it_lo;
    logic             div_ge;

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
    assign div_sh  = {hi, lo[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, b_reg});
    assign div_sub = div_sh[WIDTH-1:0] - b_reg;
    assign it_hi   = op_reg[2] ? (div_ge ? div_sub : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
    assign it_lo   = op_reg[2] ? {lo[WIDTH-2:0], div_ge} : {mul_sum[0], lo[WIDTH-1:1]};

    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   div_raw, div_fix, mdu_res;

    assign prod    = {it_hi, it_lo};
    assign prod_s  = neg_reg ? -prod : prod;
    assign div_raw = op_reg[1] ? it_hi : it_lo;
    assign div_fix = neg_reg ? -div_raw : div_raw;
    assign mdu_res = op_reg[2] ? div_fix
                   : ((op_reg[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]);

    always_comb begin
        state_nx  = state;
        result_nx = result;
        cnt_nx    = cnt;
        hi_nx     = hi;
        lo_nx     = lo;
        b_nx      = b_reg;
        op_nx     = op_reg;
        neg_nx    = neg_reg;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        take      = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                take     = in_valid;
            end
            CALC: begin
                busy   = 1'b1;
                hi_nx  = it_hi;
                lo_nx  = it_lo;
                cnt_nx = cnt + SHW'(1);
                if (cnt == SHW'(WIDTH-1)) begin
                    result_nx = mdu_res;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    take = in_valid;
                    if (!in_valid)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (take) begin
            if (is_mdu && !special) begin
                state_nx = CALC;
                cnt_nx   = '0;
                hi_nx    = '0;
                lo_nx    = operator[2] ? a_mag : b_mag;
                b_nx     = operator[2] ? b_mag : a_mag;
                op_nx    = operator[2:0];
                neg_nx   = neg_acc;
            end else begin
                state_nx  = DONE;
                result_nx = special ? spec_res : alu_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            neg_reg <= 1'b0;
        end else begin
            state   <= state_nx;
            result  <= result_nx;
            cnt     <= cnt_nx;
            hi      <= hi_nx;
            lo      <= lo_nx;
            b_reg   <= b_nx;
            op_reg  <= op_nx;
            neg_reg <= neg_nx;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed literal cases plus randomized traffic against a
// plain-arithmetic reference model with a cycle-level handshake monitor.
module tb_alu_mdu;
    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  operand_1 = '0;
    logic [WIDTH-1:0]  operand_2 = '0;
    logic [4:0]        operator = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  result;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    alu_mdu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand_1(operand_1), .operand_2(operand_2), .operator(operator),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: results straight from the operation definitions
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        ia = a; ib = b; sa = ia; sb = ib; ub = longint'({32'b0, b});
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (ia < ib) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'($signed(a) >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd16: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            5'd17: begin p = 64'(sa * sb); return p[63:32]; end
            5'd18: begin p = 64'(sa * ub); return p[63:32]; end
            5'd19: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_long(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 5'd16 && op <= 5'd19) return 1'b1;
        if (op >= 5'd20 && op <= 5'd23) begin
            if (b == 0) return 1'b0;
            if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    typedef struct {
        logic [31:0] res;
        int          lat;
        bit          lng;
        int          acc;
    } exp_t;
    exp_t q[$];

    // Cycle monitor: expected handshake state and results derived from the queue
    always @(negedge clk) begin
        bit   exp_ov, exp_busy, exp_ir;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_result", result, 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            cyc++;
            exp_ov = 1'b0;
            exp_busy = 1'b0;
            if (q.size() > 0) begin
                exp_ov = ((cyc - q[0].acc) >= q[0].lat);
                exp_busy = q[$].lng && ((cyc - q[$].acc) <= WIDTH);
            end
            exp_ir = !exp_busy && (!exp_ov || out_ready);
            chk("mon_out_valid", 32'(out_valid), 32'(exp_ov));
            chk("mon_busy", 32'(busy), 32'(exp_busy));
            chk("mon_in_ready", 32'(in_ready), 32'(exp_ir));
            if (exp_ov) chk("mon_result", result, q[0].res);
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                e.res = model(operator, operand_1, operand_2);
                e.lng = is_long(operator, operand_1, operand_2);
                e.lat = e.lng ? WIDTH + 1 : 1;
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        operator = op; operand_1 = a; operand_2 = b; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(output int lat, output int bz);
        lat = 0; bz = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bz++;
            if (out_valid) break;
        end
    endtask

    task automatic run_lit(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat, input int exp_bz);
        int lat, bz;
        out_ready = 1'b1;
        send(op, a, b);
        wait_ov(lat, bz);
        chk(name, result, exp);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy"}, 32'(bz), 32'(exp_bz));
    endtask

    logic [4:0] ops [0:22] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                               5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                               5'd11, 5'd15, 5'd24, 5'd31};

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  lat, bz;
        bit  acc;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Back-to-back base ops
        @(posedge clk); #1;
        out_ready = 1'b1;
        operator = 5'd0; operand_1 = 32'd5; operand_2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        operator = 5'd7; operand_1 = 32'h8000_0000; operand_2 = 32'h24;
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_5_7", result, 32'h0000_000C);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("sra_valid", 32'(out_valid), 32'd1);
        chk("sra_80000000_4", result, 32'hF800_0000);

        run_lit("mulhu", 5'd19, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33, 32);
        run_lit("mulh", 5'd17, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 32);
        run_lit("mul", 5'd16, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 32);
        run_lit("div_neg", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
        run_lit("rem_neg", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
        run_lit("divu", 5'd21, 32'd100, 32'd7, 32'd14, 33, 32);
        run_lit("remu", 5'd23, 32'd100, 32'd7, 32'd2, 33, 32);
        run_lit("divu_zero", 5'd21, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_lit("remu_zero", 5'd23, 32'd7, 32'd0, 32'd7, 1, 0);
        run_lit("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_lit("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run_lit("unknown_op", 5'd12, 32'd3, 32'd4, 32'd0, 1, 0);

        // Backpressure on a completed multiply
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(5'd16, 32'd3, 32'd5);
        wait_ov(lat, bz);
        chk("bp_mul_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_result", result, 32'd15);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        operator = 5'd0; operand_1 = 32'd1; operand_2 = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_add_valid", 32'(out_valid), 32'd1);
        chk("bp_add_result", result, 32'd2);

        // Reset during a divide
        send(5'd21, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1 chk("abort_in_ready", 32'(in_ready), 32'd1);
        run_lit("divu_9_3", 5'd21, 32'd9, 32'd3, 32'd3, 33, 32);

        // Randomized traffic with random backpressure and idle gaps
        @(posedge clk); #1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 2) != 0);
                if (in_valid) begin
                    operator  = ops[$urandom_range(0, 22)];
                    operand_1 = rand_val();
                    operand_2 = rand_val();
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
